// File: rtl/layer2_frame_packer.sv
// Packs source payload words into layer2 frames: header, escaped payload, length, EOF marker.
// One FIFO word is issued per cycle at most, only while the downstream FIFO has room.
module layer2_frame_packer #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned MAX_LEN = 1023
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             fifo_wr_en,
    output logic [WIDTH-1:0] fifo_wr_data,
    input  logic             fifo_full,
    input  logic             fifo_almost_full,
    output logic             frame_done,
    output logic [7:0]       frame_seq,
    output logic             busy,
    output logic             trunc_err
);

    localparam logic [15:0] EofWord = 16'hFAF1;
    localparam logic [15:0] AltWord = 16'hF1FA;
    localparam logic [15:0] EscWord = 16'hFAFE;
    localparam logic [15:0] MaxLen  = 16'(MAX_LEN);

    typedef enum logic [2:0] {StIdle, StHdr, StData, StEsc, StLen, StEof} state_e;

    state_e           state_q, state_d;
    logic [15:0]      count_q, count_d;
    logic [WIDTH-1:0] esc_q, esc_d;
    logic             close_q, close_d;
    logic             wr_en_q, wr_en_d;
    logic [WIDTH-1:0] wr_data_q, wr_data_d;
    logic             done_q, done_d;
    logic [7:0]       seq_q, seq_d;
    logic             trunc_q, trunc_d;

    logic        can_issue;
    logic        xfer;
    logic        is_special;
    logic [15:0] count_inc;
    logic        hit_max;
    logic        closing;

    assign can_issue  = !fifo_full && !fifo_almost_full;
    assign in_ready   = (state_q == StData) && can_issue;
    assign xfer       = in_valid && in_ready;
    assign is_special = (in_data == EofWord) || (in_data == AltWord) || (in_data == EscWord);
    assign count_inc  = count_q + 16'd1;
    assign hit_max    = (count_inc == MaxLen);
    assign closing    = in_last || hit_max;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        esc_d     = esc_q;
        close_d   = close_q;
        wr_en_d   = 1'b0;
        wr_data_d = wr_data_q;
        done_d    = 1'b0;
        seq_d     = seq_q;
        trunc_d   = trunc_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) state_d = StHdr;
            end
            StHdr: begin
                if (can_issue) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = {8'hA5, seq_q};
                    state_d   = StData;
                end
            end
            StData: begin
                if (xfer) begin
                    count_d = count_inc;
                    wr_en_d = 1'b1;
                    if (hit_max && !in_last) trunc_d = 1'b1;
                    if (is_special) begin
                        // Escape prefix now, transformed word next; remember the close decision.
                        wr_data_d = EscWord;
                        esc_d     = in_data ^ 16'h00FF;
                        close_d   = closing;
                        state_d   = StEsc;
                    end else begin
                        wr_data_d = in_data;
                        state_d   = closing ? StLen : StData;
                    end
                end
            end
            StEsc: begin
                if (can_issue) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = esc_q;
                    close_d   = 1'b0;
                    state_d   = close_q ? StLen : StData;
                end
            end
            StLen: begin
                if (can_issue) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = count_q;
                    state_d   = StEof;
                end
            end
            StEof: begin
                if (can_issue) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = EofWord;
                    done_d    = 1'b1;
                    seq_d     = seq_q + 8'd1;
                    count_d   = 16'd0;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= StIdle;
            count_q   <= 16'd0;
            esc_q     <= '0;
            close_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            seq_q     <= 8'h00;
            trunc_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            esc_q     <= esc_d;
            close_q   <= close_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
            seq_q     <= seq_d;
            trunc_q   <= trunc_d;
        end
    end

    assign fifo_wr_en   = wr_en_q;
    assign fifo_wr_data = wr_data_q;
    assign frame_done   = done_q;
    assign frame_seq    = seq_q;
    assign busy         = (state_q != StIdle);
    assign trunc_err    = trunc_q;

endmodule

// File: doc/layer2_frame_packer.md
LAYER2_FRAME_PACKER -- requirements
Module: layer2_frame_packer

Interface
REQ-001 Parameter WIDTH, 16: data word width; fixed at 16 because marker values are 16-bit.
REQ-002 Parameter MAX_LEN, 1023: maximum payload words per frame, range 1..65535.
REQ-003 clk  in  1  clock; all logic on rising edge.
REQ-004 rstn  in  1  reset, asynchronous, active-low.
REQ-005 in_valid  in  1  source word valid.
REQ-006 in_data  in  16  source payload word.
REQ-007 in_last  in  1  marks final payload word of frame; qualified by in_valid.
REQ-008 in_ready  out  1  packer accepts in_data this cycle; a transfer is in_valid & in_ready.
REQ-009 fifo_wr_en  out  1  registered write strobe to downstream layer2 FIFO.
REQ-010 fifo_wr_data  out  16  registered write word.
REQ-011 fifo_full, fifo_almost_full  in  1 each  downstream FIFO status.
REQ-012 frame_done  out  1  one-cycle pulse in the cycle the EOF word is driven on fifo_wr_en.
REQ-013 frame_seq  out  8  sequence number of the next frame.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 trunc_err  out  1  sticky flag; set when a frame is closed by MAX_LEN.

Function
REQ-016 Frame format, in order:
  - header {8'hA5, frame_seq}
  - escaped payload words
  - length word (payload source-word count, 16 bits)
  - EOF marker 16'hFAF1
REQ-017 Escaping: a payload word equal to 16'hFAF1, 16'hF1FA or 16'hFAFE is emitted as 16'hFAFE followed by (word XOR 16'h00FF), i.e. FA0E, F105, FA01.
  - All other payload words are emitted unchanged.
  - Escapes do not increment the length count.
REQ-018 Issue rule:
  - can_issue = !fifo_full & !fifo_almost_full.
  - At most one word is issued per cycle, and only when can_issue is high.
  - An issued word appears on fifo_wr_en/fifo_wr_data on the next cycle.
  - fifo_wr_en is 0 in every other cycle.
REQ-019 State machine IDLE, HDR, DATA, ESC, LEN, EOF:
  - IDLE->HDR when in_valid=1. No word is consumed.
  - HDR: issue header when can_issue, then ->DATA.
  - DATA: in_ready = can_issue.
    - On transfer of a plain word: issue it and increment count.
    - On transfer of a special word: issue FAFE, store the transformed word, increment count, ->ESC.
  - ESC: in_ready=0; issue the stored word when can_issue. Then ->LEN if the closing condition was latched, else ->DATA.
  - Closing condition: the transferred word had in_last=1, or count reached MAX_LEN. From DATA this goes ->LEN directly if no escape is pending.
  - LEN: issue count when can_issue, then ->EOF.
  - EOF: issue 16'hFAF1 when can_issue, then ->IDLE and clear count.
REQ-020 in_ready is 0 in IDLE, HDR, ESC, LEN and EOF.
REQ-021 When count reaches MAX_LEN without in_last:
  - set trunc_err;
  - close the frame normally;
  - the remaining source words form the next frame.
  - in_last is ignored outside DATA.
REQ-022 frame_seq increments when the EOF word is issued, wrapping 255->0.
REQ-023 Back-pressure can stall any state for any number of cycles without loss or duplication of words.
  - Stalled in_data need not be held stable by the packer; the source holds it per valid/ready rules.
REQ-024 Minimum frame is 4 FIFO words: header, 1 payload, length=1, FAF1.
  - With no stalls, consecutive frames have one idle decision cycle in IDLE.

Reset
REQ-025 Asserting rstn low asynchronously forces:
  - state IDLE; count and the escape register to 0;
  - in_ready, fifo_wr_en, frame_done, busy, trunc_err to 0;
  - fifo_wr_data to 16'h0000; frame_seq to 8'h00.
REQ-026 Reset mid-frame abandons the partial frame. No EOF is emitted, and the first frame after reset uses header 16'hA500.
REQ-027 Reset is the only way to clear trunc_err.

Verification
REQ-028 After reset, one word 16'h1234 with in_last, FIFO empty -> writes A500, 1234, 0001, FAF1 on 4 consecutive cycles; frame_done with FAF1; frame_seq becomes 01.
REQ-029 Payload 0001, FAF1, F1FA, FAFE, 0002 with last on 0002 -> writes A5xx, 0001, FAFE, FA0E, FAFE, F105, FAFE, FA01, 0002, 0005, FAF1.
REQ-030 fifo_almost_full held high for 5 cycles mid-payload -> no fifo_wr_en and in_ready=0 during the hold; the output stream is identical to the unstalled one.
REQ-031 MAX_LEN=3, 5 words with no in_last -> frame 1 has payload of 3 words, length 0003, FAF1, trunc_err=1; frame 2 has the next 2 words only if in_last is set on word 5.
REQ-032 rstn pulsed low in ESC state -> all outputs return to reset values within the reset; the next frame starts with header A500.
REQ-033 256 back-to-back frames -> frame_seq wraps to 00 and the header of frame 257 is 16'hA500.
